// File: rtl/ptr_sync_pkg.sv
// Shared helpers for Gray-coded pointer synchronizers: code conversion, bit counting, stage limits.
// Functions work on a 16-bit container; callers pass their real width and truncate the result.
package ptr_sync_pkg;

   localparam int MIN_SYNC_STAGES = 2;
   localparam int MAX_SYNC_STAGES = 4;
   localparam int MIN_PTR_WIDTH   = 2;
   localparam int MAX_PTR_WIDTH   = 16;

   typedef logic [MAX_PTR_WIDTH-1:0] ptr_max_t;
   typedef logic [4:0]               ptr_cnt_t;

   function automatic ptr_max_t width_mask(input int width);
      ptr_max_t m;
      m = '0;
      for (int i = 0; i < MAX_PTR_WIDTH; i++) begin
         if (i < width) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Running XOR from the MSB down: b[i] = g[MSB] ^ ... ^ g[i].
   function automatic ptr_max_t gray2bin(input ptr_max_t g, input int width);
      ptr_max_t b;
      logic     acc;
      b   = '0;
      acc = 1'b0;
      for (int i = MAX_PTR_WIDTH - 1; i >= 0; i--) begin
         if (i < width) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

   function automatic ptr_max_t bin2gray(input ptr_max_t b, input int width);
      return (b ^ (b >> 1)) & width_mask(width);
   endfunction

   function automatic ptr_cnt_t popcount(input ptr_max_t v);
      ptr_cnt_t cnt;
      cnt = '0;
      for (int i = 0; i < MAX_PTR_WIDTH; i++) begin
         cnt = cnt + ptr_cnt_t'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Bare flop chain for a multi-bit Gray pointer entering the clock_read domain; no logic between stages.
// Kept as its own instance so CDC constraints and attributes have a single anchor.
module sync_chain #(
   parameter int WIDTH  = 7,
   parameter int STAGES = 2
) (
   input  logic             clock_read,
   input  logic             read_reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clock_read or negedge read_reset_n) begin
      if (!read_reset_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Synchronizes a Gray FIFO pointer into clock_read, then registers binary value, step delta and advance flag.
// Sticky gray_error flags any synchronized step that changes more than one Gray bit.
module ptr_sync_gray
   import ptr_sync_pkg::*;
#(
   parameter int PTR_WIDTH   = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clock_read,
   input  logic                 read_reset_n,
   input  logic [PTR_WIDTH-1:0] gray_pointer,
   input  logic                 error_clear,
   output logic [PTR_WIDTH-1:0] sync_gray_pointer,
   output logic [PTR_WIDTH-1:0] sync_bin_pointer,
   output logic [PTR_WIDTH-1:0] pointer_delta,
   output logic                 pointer_advanced,
   output logic                 gray_error
);

   if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("ptr_sync_gray: SYNC_STAGES must lie in 2..4");
   end
   if (PTR_WIDTH < MIN_PTR_WIDTH || PTR_WIDTH > MAX_PTR_WIDTH) begin : g_bad_width
      $error("ptr_sync_gray: PTR_WIDTH must lie in 2..16");
   end

   logic [PTR_WIDTH-1:0] sync_gray;
   logic [PTR_WIDTH-1:0] bin_next;
   logic [PTR_WIDTH-1:0] prev_gray;
   logic [PTR_WIDTH-1:0] delta_d;
   logic                 advanced_d;
   logic                 multi_bit;
   logic                 error_d;

   logic [PTR_WIDTH-1:0] sync_bin_q;
   logic [PTR_WIDTH-1:0] delta_q;
   logic                 advanced_q;
   logic                 error_q;

   sync_chain #(
      .WIDTH  (PTR_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .clock_read   (clock_read),
      .read_reset_n (read_reset_n),
      .d_i          (gray_pointer),
      .q_o          (sync_gray)
   );

   // The previous synchronized Gray value is recovered from sync_bin_q rather than stored again.
   always_comb begin
      bin_next   = PTR_WIDTH'(gray2bin(ptr_max_t'(sync_gray), PTR_WIDTH));
      prev_gray  = PTR_WIDTH'(bin2gray(ptr_max_t'(sync_bin_q), PTR_WIDTH));
      delta_d    = bin_next - sync_bin_q;
      advanced_d = (bin_next != sync_bin_q);
      multi_bit  = (popcount(ptr_max_t'(sync_gray ^ prev_gray)) > ptr_cnt_t'(1));
      error_d    = multi_bit | (error_q & ~error_clear);
   end

   always_ff @(posedge clock_read or negedge read_reset_n) begin
      if (!read_reset_n) begin
         sync_bin_q <= '0;
         delta_q    <= '0;
         advanced_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         sync_bin_q <= bin_next;
         delta_q    <= delta_d;
         advanced_q <= advanced_d;
         error_q    <= error_d;
      end
   end

   assign sync_gray_pointer = sync_gray;
   assign sync_bin_pointer  = sync_bin_q;
   assign pointer_delta     = delta_q;
   assign pointer_advanced  = advanced_q;
   assign gray_error        = error_q;

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Directed and randomized checks of two ptr_sync_gray configurations against a pointer-history model.
module tb_ptr_sync_gray;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] g0 = '0;
   logic [4:0] g1 = '0;
   logic       clr = 1'b0;

   logic [6:0] sg0, sb0, dl0;
   logic       ad0, er0;
   logic [4:0] sg1, sb1, dl1;
   logic       ad1, er1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ptr_sync_gray #(.PTR_WIDTH(7), .SYNC_STAGES(2)) dut0 (
      .clock_read        (clk),
      .read_reset_n      (rst_n),
      .gray_pointer      (g0),
      .error_clear       (clr),
      .sync_gray_pointer (sg0),
      .sync_bin_pointer  (sb0),
      .pointer_delta     (dl0),
      .pointer_advanced  (ad0),
      .gray_error        (er0)
   );

   ptr_sync_gray #(.PTR_WIDTH(5), .SYNC_STAGES(3)) dut1 (
      .clock_read        (clk),
      .read_reset_n      (rst_n),
      .gray_pointer      (g1),
      .error_clear       (clr),
      .sync_gray_pointer (sg1),
      .sync_bin_pointer  (sb1),
      .pointer_delta     (dl1),
      .pointer_advanced  (ad1),
      .gray_error        (er1)
   );

   // Reference model: samples taken at each edge, synchronized value = sample STAGES edges old.
   int          mw [2] = '{7, 5};
   int          ms [2] = '{2, 3};
   logic [15:0] hist [2][4];
   logic [15:0] m_cur [2];
   logic [15:0] m_prev [2];
   logic        m_err [2];
   logic [15:0] e_sg [2];
   logic [15:0] e_sb [2];
   logic [15:0] e_dl [2];
   logic        e_ad [2];

   function automatic logic [15:0] g2b(input logic [15:0] g);
      logic [15:0] b;
      b = '0;
      for (int s = 0; s < 16; s++) b = b ^ (g >> s);
      return b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) hist[k][i] = '0;
         m_cur[k] = '0; m_prev[k] = '0; m_err[k] = 1'b0;
         e_sg[k] = '0; e_sb[k] = '0; e_dl[k] = '0; e_ad[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input logic [15:0] sample, input logic c);
      logic [15:0] mask;
      logic [15:0] nb, pb;
      mask = (16'h1 << mw[k]) - 16'h1;
      nb = g2b(m_cur[k]);
      pb = g2b(m_prev[k]);
      e_sb[k] = nb;
      e_dl[k] = (nb - pb) & mask;
      e_ad[k] = (nb != pb);
      m_err[k] = ($countones(m_cur[k] ^ m_prev[k]) > 1) || (m_err[k] && !c);
      for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = sample;
      m_prev[k] = m_cur[k];
      m_cur[k] = hist[k][ms[k]-1];
      e_sg[k] = m_cur[k];
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d0_sync_gray", 16'(sg0), e_sg[0]);
      chk("d0_sync_bin",  16'(sb0), e_sb[0]);
      chk("d0_delta",     16'(dl0), e_dl[0]);
      chk("d0_advanced",  16'(ad0), 16'(e_ad[0]));
      chk("d0_error",     16'(er0), 16'(m_err[0]));
      chk("d1_sync_gray", 16'(sg1), e_sg[1]);
      chk("d1_sync_bin",  16'(sb1), e_sb[1]);
      chk("d1_delta",     16'(dl1), e_dl[1]);
      chk("d1_advanced",  16'(ad1), 16'(e_ad[1]));
      chk("d1_error",     16'(er1), 16'(m_err[1]));
   endtask

   // Called at posedge+1: drive inputs, advance one edge, compare at posedge+1.
   task automatic cyc(input logic [6:0] a, input logic [4:0] b, input logic c);
      g0 = a; g1 = b; clr = c;
      @(posedge clk);
      #1;
      if (rst_n) begin
         model_step(0, 16'(a), c);
         model_step(1, 16'(b), c);
      end else begin
         model_reset();
      end
      check_all();
   endtask

   task automatic rst_assert();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
   endtask

   initial begin
      logic [15:0] p0, p1;
      int r;
      model_reset();
      #1 rst_n = 1'b0;

      // Reset held with a nonzero input, then first update after release.
      cyc(7'h07, 5'h00, 1'b0);
      cyc(7'h07, 5'h00, 1'b0);
      chk("t1_rst_bin", 16'(sb0), 16'd0);
      rst_n = 1'b1;
      cyc(7'h07, 5'h00, 1'b0);
      cyc(7'h07, 5'h00, 1'b0);
      chk("t1_sgray_e2", 16'(sg0), 16'h07);
      cyc(7'h07, 5'h00, 1'b0);
      chk("t1_bin_e3", 16'(sb0), 16'd5);
      chk("t1_delta_e3", 16'(dl0), 16'd5);
      chk("t1_adv_e3", 16'(ad0), 16'd1);
      chk("t1_err_e3", 16'(er0), 16'd1);
      cyc(7'h07, 5'h00, 1'b0);
      chk("t1_adv_e4", 16'(ad0), 16'd0);
      cyc(7'h07, 5'h00, 1'b1);
      chk("t1_err_clr", 16'(er0), 16'd0);

      // Single legal step.
      rst_assert();
      g0 = '0; g1 = 5'h01; rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(7'h00, 5'h01, 1'b0);
      cyc(7'h01, 5'h01, 1'b0);
      cyc(7'h01, 5'h01, 1'b0);
      cyc(7'h01, 5'h01, 1'b0);
      chk("t2_bin", 16'(sb0), 16'd1);
      chk("t2_adv", 16'(ad0), 16'd1);
      chk("t2_err", 16'(er0), 16'd0);
      cyc(7'h01, 5'h01, 1'b0);
      chk("t2_adv_off", 16'(ad0), 16'd0);

      // Wrap-around through 125, 126, 127, 0.
      rst_assert();
      g0 = 7'h43; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(7'h43, 5'h01, 1'b0);
      cyc(7'h43, 5'h01, 1'b1);
      cyc(7'h41, 5'h01, 1'b0);
      cyc(7'h40, 5'h01, 1'b0);
      cyc(7'h00, 5'h01, 1'b0);
      chk("t3_bin126", 16'(sb0), 16'd126);
      chk("t3_dl126", 16'(dl0), 16'd1);
      cyc(7'h00, 5'h01, 1'b0);
      chk("t3_bin127", 16'(sb0), 16'd127);
      cyc(7'h00, 5'h01, 1'b0);
      chk("t3_bin0", 16'(sb0), 16'd0);
      chk("t3_dl0", 16'(dl0), 16'd1);
      chk("t3_err", 16'(er0), 16'd0);

      // Illegal two-bit jump, sticky error, clear, set-beats-clear; second config alongside.
      rst_assert();
      g0 = '0; g1 = 5'h01; rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(7'h00, 5'h01, 1'b0);
      cyc(7'h03, 5'h03, 1'b0);
      cyc(7'h03, 5'h03, 1'b0);
      cyc(7'h03, 5'h03, 1'b0);
      chk("t4_delta", 16'(dl0), 16'd2);
      chk("t4_adv", 16'(ad0), 16'd1);
      chk("t4_err", 16'(er0), 16'd1);
      chk("t6_sgray_e3", 16'(sg1), 16'h03);
      cyc(7'h03, 5'h03, 1'b0);
      chk("t6_bin_e4", 16'(sb1), 16'd2);
      chk("t6_err", 16'(er1), 16'd0);
      cyc(7'h03, 5'h03, 1'b0);
      chk("t4_err_sticky", 16'(er0), 16'd1);
      cyc(7'h03, 5'h03, 1'b1);
      chk("t4_err_cleared", 16'(er0), 16'd0);
      cyc(7'h00, 5'h03, 1'b0);
      cyc(7'h00, 5'h03, 1'b0);
      cyc(7'h00, 5'h03, 1'b1);
      chk("t4_set_wins", 16'(er0), 16'd1);
      chk("t4_delta_back", 16'(dl0), 16'd126);

      // Reset mid-stream.
      rst_assert();
      g0 = 7'h7F; g1 = '0; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(7'h7F, 5'h00, 1'b0);
      chk("t5_bin55", 16'(sb0), 16'h55);
      rst_assert();
      chk("t5_rst_bin", 16'(sb0), 16'd0);
      chk("t5_rst_sgray", 16'(sg0), 16'd0);
      chk("t5_rst_err", 16'(er0), 16'd0);
      cyc(7'h00, 5'h00, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(7'h00, 5'h00, 1'b0);
         chk("t5_no_adv", 16'(ad0), 16'd0);
      end

      // Randomized pointer traffic with occasional illegal jumps, clears and resets.
      p0 = '0; p1 = '0;
      for (int n = 0; n < 400; n++) begin
         if (n % 130 == 129) begin
            rst_assert();
            rst_n = 1'b1;
         end
         r = $urandom_range(0, 99);
         if (r < 5) p0 = p0 + 16'($urandom_range(2, 10));
         else if (r < 55) p0 = p0 + 16'd1;
         r = $urandom_range(0, 99);
         if (r < 5) p1 = p1 + 16'($urandom_range(2, 10));
         else if (r < 55) p1 = p1 + 16'd1;
         cyc(7'(p0 ^ (p0 >> 1)), 5'(p1 ^ (p1 >> 1)), ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
